// File: rtl/alu_exec.sv
// ---------------------------------------------------------------------------
// alu_exec : multi-cycle ALU with shift-add multiplier and one-cycle write-back
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_exec #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [3:0]       dest,
  output logic             ready,
  output logic [WIDTH-1:0] writeData,
  output logic [3:0]       write,
  output logic             regWrite,
  output logic             zero,
  output logic             overflow,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [3:0]         dest_q, dest_d;
  logic [WIDTH-1:0]   writeData_q, writeData_d;
  logic [3:0]         write_q, write_d;
  logic               regWrite_q, regWrite_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   sum, diff, alu_res;
  logic               alu_ovf;
  logic [2*WIDTH-1:0] mul_sum;

  assign sum  = srcA + srcB;
  assign diff = srcA - srcB;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (srcA[WIDTH-1] == srcB[WIDTH-1]) && (sum[WIDTH-1] != srcA[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (srcA[WIDTH-1] != srcB[WIDTH-1]) && (diff[WIDTH-1] != srcA[WIDTH-1]);
      end
      OP_AND:  alu_res = srcA & srcB;
      OP_OR:   alu_res = srcA | srcB;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      OP_SLL:  alu_res = srcA << srcB[CW-1:0];
      default: alu_res = '0;
    endcase
  end

  // One multiplier bit per cycle: add the shifted multiplicand when the LSB is set.
  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    dest_d      = dest_q;
    writeData_d = writeData_q;
    write_d     = write_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    regWrite_d  = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, srcA};
            mplier_d = srcB;
            dest_d   = dest;
          end else begin
            state_d     = S_WB;
            writeData_d = alu_res;
            write_d     = dest;
            zero_d      = (alu_res == '0);
            ovf_d       = alu_ovf;
            regWrite_d  = (op != OP_ILL);
            err_d       = (op == OP_ILL);
          end
        end
      end
      S_MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d     = S_WB;
          cnt_d       = '0;
          writeData_d = mul_sum[WIDTH-1:0];
          write_d     = dest_q;
          zero_d      = (mul_sum[WIDTH-1:0] == '0);
          ovf_d       = |mul_sum[2*WIDTH-1:WIDTH];
          regWrite_d  = 1'b1;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      dest_q      <= '0;
      writeData_q <= '0;
      write_q     <= '0;
      regWrite_q  <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      dest_q      <= dest_d;
      writeData_q <= writeData_d;
      write_q     <= write_d;
      regWrite_q  <= regWrite_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign writeData = writeData_q;
  assign write     = write_q;
  assign regWrite  = regWrite_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter: WIDTH, 16, data width of operands and result; all values below assume 16.
REQ-002 SHALL have port: clk  input  1  single clock, all state changes on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request to execute one operation.
REQ-005 SHALL have port: op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed), 101 SLL (srcA << srcB[3:0]), 110 MUL (low 16 bits, unsigned), 111 illegal.
REQ-006 SHALL have port: srcA  input  16  first operand, from register-file out1.
REQ-007 SHALL have port: srcB  input  16  second operand, from register-file out2.
REQ-008 SHALL have port: dest  input  4  destination register index.
REQ-009 SHALL have port: ready  output  1  high only in IDLE; start accepted only when high.
REQ-010 SHALL have port: writeData  output  16  registered result, to register-file writeData.
REQ-011 SHALL have port: write  output  4  registered destination, to register-file write.
REQ-012 SHALL have port: regWrite  output  1  one-cycle write-back strobe, to register-file regWrite.
REQ-013 SHALL have port: zero  output  1  result == 0, valid in WB.
REQ-014 SHALL have port: overflow  output  1  signed overflow (ADD/SUB) or product >= 2^16 (MUL), valid in WB.
REQ-015 SHALL have port: err  output  1  one-cycle pulse in WB for illegal opcode.

Function
REQ-016 SHALL implement FSM states IDLE, MUL, WB.
REQ-017 SHALL accept when start=1 and state=IDLE at a rising edge; op, srcA, srcB, dest latched at that edge, later input changes ignored.
REQ-018 SHALL ignore start while not in IDLE (no queuing, no effect).
REQ-019 SHALL, for ops 000-101 and 111, go IDLE->WB at the accept edge; result, write, flags registered at that edge.
REQ-020 SHALL, for MUL, go IDLE->MUL at the accept edge, run 16 shift-add iterations (one per cycle, 4-bit counter 0..15), go MUL->WB on the edge ending iteration 15.
REQ-021 SHALL in WB drive regWrite=1 (err=1 instead, regWrite=0, for op 111) for exactly one cycle, then return to IDLE on the next edge.
REQ-022 SHALL give latency: accept edge N -> regWrite high between edges N+1..N+2 for single-cycle ops; between N+16..N+17 for MUL; register file writes at edge N+2 / N+17.
REQ-023 SHALL compute ADD/SUB/SLL modulo 2^16; SLT result 16'd1 or 16'd0; shift amount srcB[3:0] only.
REQ-024 SHALL hold writeData, write, zero, overflow stable from WB until the next WB overwrites them; regWrite and err low outside WB.
REQ-025 SHALL produce writeData=0, zero=1, overflow=0 for op 111.
REQ-026 SHALL treat dest=0 like any other register (no hardwired zero).

Reset
REQ-027 SHALL, on reset_n=0, immediately force state IDLE, counter 0, writeData=0, write=0, regWrite=0, zero=0, overflow=0, err=0; ready=1.
REQ-028 SHALL abort any MUL or WB in progress on reset with no regWrite pulse; operation resumes only after reset_n deasserted and a new start.

Verification
REQ-029 SHALL verify ADD: srcA=16, srcB=10, dest=10 -> writeData=26, write=10, regWrite exactly one cycle, one cycle after accept, zero=0.
REQ-030 SHALL verify SUB/SLT: 10-10 -> writeData=0, zero=1; SLT srcA=16'hFFFF, srcB=1 -> writeData=1; ADD 16'h7FFF+1 -> 16'h8000, overflow=1.
REQ-031 SHALL verify MUL: 300*300 -> writeData=24464, overflow=1, ready low 17 cycles, regWrite high 16 cycles after accept edge.
REQ-032 SHALL verify start pulsed with op=ADD during MUL cycle 5 -> ignored, single regWrite with MUL result only.
REQ-033 SHALL verify reset_n low during MUL iteration 8 -> all outputs 0, ready=1 immediately, no regWrite thereafter.
REQ-034 SHALL verify op=111 -> err one-cycle pulse, regWrite never asserted, writeData=0.
